mpsoc_uart_rx_ctrl: RTL and testbench

- Controls and buffers the UART receive core: owns the core's config inputs, takes received characters into a DEPTH-entry FIFO and presents them to the bus register file.
- Config changes are applied only when the core is idle, so no character is ever received with mixed settings.
- Generates overrun status, a character-timeout flag and the RX interrupt.

---
 rtl/mpsoc_uart_rx_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mpsoc_uart_rx_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_uart_rx_ctrl.sv
// UART receive controller: idle-safe config shadowing for the RX core, FWFT receive FIFO,
// sticky overrun, character timeout and RX interrupt generation.
module mpsoc_uart_rx_ctrl #(
    parameter int DEPTH   = 16,
    parameter int TO_BITS = 40
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [15:0]              reg_div_i,
    input  logic                     reg_en_i,
    input  logic                     reg_parity_en_i,
    input  logic [1:0]               reg_bits_i,
    input  logic [1:0]               reg_trig_i,
    input  logic                     reg_flush_i,
    output logic [15:0]              cfg_div_o,
    output logic                     cfg_en_o,
    output logic                     cfg_parity_en_o,
    output logic [1:0]               cfg_bits_o,
    input  logic                     core_busy_i,
    input  logic [7:0]               core_data_i,
    input  logic                     core_valid_i,
    output logic                     core_ready_o,
    output logic [7:0]               rd_data_o,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     overrun_o,
    input  logic                     ovr_clr_i,
    output logic                     timeout_o,
    output logic                     irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TO_BITS + 1);

    typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_DRAIN} state_t;

    state_t          state;
    logic            core_valid_p1;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [15:0]     presc;
    logic [TW-1:0]   ticks;

    logic cfg_changed, push, pop, full, push_acc, wr_en, ovr_set, tick, evt, tmr_clr;

    function automatic logic [CW-1:0] trig_level(input logic [1:0] sel);
        case (sel)
            2'b00:   return CW'(1);
            2'b01:   return CW'(DEPTH / 4);
            2'b10:   return CW'(DEPTH / 2);
            default: return CW'(DEPTH - 2);
        endcase
    endfunction

    assign cfg_changed = (reg_div_i != cfg_div_o) | (reg_parity_en_i != cfg_parity_en_o) |
                         (reg_bits_i != cfg_bits_o);

    // Config FSM: the shadow only reloads while the core is idle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state           <= ST_OFF;
            cfg_div_o       <= '0;
            cfg_en_o        <= 1'b0;
            cfg_parity_en_o <= 1'b0;
            cfg_bits_o      <= '0;
            core_ready_o    <= 1'b0;
        end else begin
            core_ready_o <= 1'b1;
            case (state)
                ST_OFF: begin
                    if (reg_en_i) begin
                        cfg_div_o       <= reg_div_i;
                        cfg_parity_en_o <= reg_parity_en_i;
                        cfg_bits_o      <= reg_bits_i;
                        cfg_en_o        <= 1'b1;
                        state           <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!reg_en_i || cfg_changed) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!core_busy_i) begin
                        if (reg_en_i) begin
                            cfg_div_o       <= reg_div_i;
                            cfg_parity_en_o <= reg_parity_en_i;
                            cfg_bits_o      <= reg_bits_i;
                            state           <= ST_RUN;
                        end else begin
                            cfg_en_o <= 1'b0;
                            state    <= ST_OFF;
                        end
                    end
                end
                default: begin
                    cfg_en_o <= 1'b0;
                    state    <= ST_OFF;
                end
            endcase
        end
    end

    assign push     = core_valid_i & ~core_valid_p1;
    assign rd_valid_o = (fifo_count_o != '0);
    assign rd_data_o  = mem[rd_ptr];
    assign full     = (fifo_count_o == CW'(DEPTH));
    assign pop      = rd_ready_i & rd_valid_o;
    assign push_acc = push & (~full | pop);
    assign wr_en    = push_acc & ~reg_flush_i;
    assign ovr_set  = push & full & ~pop & ~reg_flush_i;

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= core_data_i;
    end

    // FIFO pointers, occupancy and overrun
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            core_valid_p1 <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count_o  <= '0;
            overrun_o     <= 1'b0;
        end else begin
            core_valid_p1 <= core_valid_i;
            overrun_o     <= ovr_set | (overrun_o & ~ovr_clr_i);
            if (reg_flush_i) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                fifo_count_o <= '0;
            end else begin
                if (push_acc) wr_ptr <= wr_ptr + 1'b1;
                if (pop)      rd_ptr <= rd_ptr + 1'b1;
                if (push_acc && !pop)      fifo_count_o <= fifo_count_o + 1'b1;
                else if (!push_acc && pop) fifo_count_o <= fifo_count_o - 1'b1;
            end
        end
    end

    assign tick    = (presc == cfg_div_o);
    assign evt     = push | pop | reg_flush_i;
    assign tmr_clr = evt | ~rd_valid_o | (state == ST_OFF);

    // Bit-period prescaler, idle tick counter, timeout and interrupt
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc     <= '0;
            ticks     <= '0;
            timeout_o <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            irq_o <= (fifo_count_o >= trig_level(reg_trig_i)) | timeout_o;
            if (tmr_clr) begin
                presc <= '0;
                ticks <= '0;
            end else if (tick) begin
                presc <= '0;
                if (ticks != TW'(TO_BITS)) ticks <= ticks + 1'b1;
            end else begin
                presc <= presc + 16'd1;
            end
            if (evt)
                timeout_o <= 1'b0;
            else if (!tmr_clr && tick && ticks == TW'(TO_BITS - 1))
                timeout_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mpsoc_uart_rx_ctrl.sv
// Bench for mpsoc_uart_rx_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_mpsoc_uart_rx_ctrl;
    localparam int DEPTH   = 16;
    localparam int TO_BITS = 40;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk, rstn;
    logic [15:0]   reg_div;
    logic          reg_en, reg_parity, reg_flush, ovr_clr, rd_ready;
    logic [1:0]    reg_bits, reg_trig;
    logic          core_busy, core_valid;
    logic [7:0]    core_data;
    logic [15:0]   cfg_div;
    logic          cfg_en, cfg_parity, core_ready, rd_valid, overrun, timeout, irq;
    logic [1:0]    cfg_bits;
    logic [7:0]    rd_data;
    logic [CW-1:0] fifo_count;

    mpsoc_uart_rx_ctrl #(.DEPTH(DEPTH), .TO_BITS(TO_BITS)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .reg_div_i(reg_div), .reg_en_i(reg_en), .reg_parity_en_i(reg_parity),
        .reg_bits_i(reg_bits), .reg_trig_i(reg_trig), .reg_flush_i(reg_flush),
        .cfg_div_o(cfg_div), .cfg_en_o(cfg_en), .cfg_parity_en_o(cfg_parity),
        .cfg_bits_o(cfg_bits), .core_busy_i(core_busy), .core_data_i(core_data),
        .core_valid_i(core_valid), .core_ready_o(core_ready),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
        .fifo_count_o(fifo_count), .overrun_o(overrun), .ovr_clr_i(ovr_clr),
        .timeout_o(timeout), .irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: enabled/draining/off mode, shadow config, a byte queue, idle-cycle timer
    int          m_mode;          // 0 off, 1 running, 2 waiting for idle core
    logic [15:0] m_div;
    logic        m_par, m_en, m_ready, m_prev_v, m_ovr, m_to, m_irq;
    logic [1:0]  m_bits;
    logic [7:0]  q[$];
    int          m_idle;
    logic        mv_push, mv_pop, mv_full, mv_evt;
    logic [15:0] mv_div_old;

    function automatic int lvl_of(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return DEPTH / 4;
            2'b10:   return DEPTH / 2;
            default: return DEPTH - 2;
        endcase
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_mode = 0; m_div = '0; m_par = 0; m_bits = '0; m_en = 0; m_ready = 0;
            m_prev_v = 0; m_ovr = 0; m_to = 0; m_irq = 0; m_idle = 0;
            q.delete();
        end else begin
            mv_push    = core_valid && !m_prev_v;
            mv_pop     = rd_ready && (q.size() != 0);
            mv_full    = (q.size() == DEPTH);
            mv_evt     = mv_push || mv_pop || reg_flush;
            mv_div_old = m_div;
            m_irq = (q.size() >= lvl_of(reg_trig)) || m_to;
            if (mv_evt) begin
                m_idle = 0; m_to = 0;
            end else if (q.size() == 0 || m_mode == 0) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TO_BITS * (int'(mv_div_old) + 1)) m_to = 1;
            end
            m_ovr = (mv_push && mv_full && !mv_pop && !reg_flush) ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
            if (reg_flush) q.delete();
            else begin
                if (mv_pop) void'(q.pop_front());
                if (mv_push && q.size() < DEPTH) q.push_back(core_data);
            end
            m_prev_v = core_valid;
            m_ready  = 1;
            if (m_mode == 0) begin
                if (reg_en) begin
                    m_div = reg_div; m_par = reg_parity; m_bits = reg_bits; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (!reg_en || reg_div != m_div || reg_parity != m_par || reg_bits != m_bits) m_mode = 2;
            end else if (!core_busy) begin
                if (reg_en) begin
                    m_div = reg_div; m_par = reg_parity; m_bits = reg_bits; m_mode = 1;
                end else m_mode = 0;
            end
            m_en = (m_mode != 0);
        end
    end

    always @(negedge clk) begin
        if (rstn && cmp_en) begin
            chk("cfg_div", cfg_div, m_div);
            chk("cfg_en", cfg_en, m_en);
            chk("cfg_parity", cfg_parity, m_par);
            chk("cfg_bits", cfg_bits, m_bits);
            chk("core_ready", core_ready, m_ready);
            chk("rd_valid", rd_valid, q.size() != 0);
            chk("fifo_count", fifo_count, q.size());
            if (q.size() != 0) chk("rd_data", rd_data, q[0]);
            chk("overrun", overrun, m_ovr);
            chk("timeout", timeout, m_to);
            chk("irq", irq, m_irq);
        end
    end

    task automatic push_len(input logic [7:0] d, input int len);
        core_data = d; core_valid = 1;
        repeat (len) @(negedge clk);
        core_valid = 0;
        @(negedge clk);
    endtask

    task automatic pop1();
        rd_ready = 1;
        @(negedge clk);
        rd_ready = 0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rstn = 0; reg_div = '0; reg_en = 0; reg_parity = 0; reg_bits = '0; reg_trig = '0;
        reg_flush = 0; ovr_clr = 0; rd_ready = 0; core_busy = 0; core_valid = 0; core_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_cfg_en", cfg_en, 0);
        chk("rst_cfg_div", cfg_div, 0);
        chk("rst_ready", core_ready, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_status", {overrun, timeout, irq, rd_valid}, 0);
        rstn = 1; cmp_en = 1;

        reg_en = 1; reg_div = 16'd9; reg_bits = 2'b11;
        repeat (2) @(negedge clk);
        chk("en_cfg_en", cfg_en, 1);
        chk("en_cfg_div", cfg_div, 9);
        chk("en_cfg_bits", cfg_bits, 3);
        chk("en_status", {overrun, timeout, irq}, 0);

        core_busy = 1; reg_bits = 2'b00;
        repeat (5) @(negedge clk);
        chk("busy_bits_held", cfg_bits, 3);
        chk("busy_en_held", cfg_en, 1);
        core_busy = 0;
        @(negedge clk);
        chk("idle_bits_loaded", cfg_bits, 0);

        push_len(8'h41, 1); push_len(8'h42, 3); push_len(8'h43, 1);
        chk("three_count", fifo_count, 3);
        chk("pop_a", rd_data, 8'h41); pop1();
        chk("pop_b", rd_data, 8'h42); pop1();
        chk("pop_c", rd_data, 8'h43); pop1();
        chk("drained", rd_valid, 0);

        for (int i = 0; i < 17; i++) push_len(8'(i), 1);
        chk("full_count", fifo_count, 16);
        chk("full_ovr", overrun, 1);
        core_data = 8'hEE; core_valid = 1; ovr_clr = 1;
        @(negedge clk);
        core_valid = 0; ovr_clr = 0;
        chk("ovr_set_wins", overrun, 1);
        @(negedge clk);
        ovr_clr = 1;
        @(negedge clk);
        ovr_clr = 0;
        chk("ovr_cleared", overrun, 0);

        core_data = 8'hA5; core_valid = 1; rd_ready = 1;
        @(negedge clk);
        core_valid = 0; rd_ready = 0;
        chk("full_pp_count", fifo_count, 16);
        chk("full_pp_ovr", overrun, 0);
        @(negedge clk);
        for (int i = 1; i < 16; i++) begin
            chk("drain_seq", rd_data, i);
            pop1();
        end
        chk("drain_last", rd_data, 8'hA5); pop1();
        chk("drain_empty", rd_valid, 0);

        push_len(8'h01, 1); push_len(8'h02, 1);
        core_data = 8'h03; core_valid = 1; reg_flush = 1;
        @(negedge clk);
        core_valid = 0; reg_flush = 0;
        chk("flush_count", fifo_count, 0);
        @(negedge clk);

        reg_trig = 2'b01;
        @(negedge clk);
        for (int i = 0; i < 3; i++) push_len(8'h10 + 8'(i), 1);
        core_data = 8'h13; core_valid = 1;
        @(negedge clk);
        core_valid = 0;
        chk("trig_count", fifo_count, 4);
        chk("trig_irq_lag", irq, 0);
        @(negedge clk);
        chk("trig_irq", irq, 1);
        reg_flush = 1;
        @(negedge clk);
        reg_flush = 0;
        @(negedge clk);

        reg_trig = 2'b11; reg_div = 16'd3;
        repeat (4) @(negedge clk);
        chk("div3", cfg_div, 3);
        core_data = 8'h55; core_valid = 1;
        @(negedge clk);
        core_valid = 0;
        k = 0;
        while (!timeout && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_latency", k, 160);
        chk("to_irq_lag", irq, 0);
        @(negedge clk);
        chk("to_irq", irq, 1);
        pop1();
        chk("to_cleared", timeout, 0);
        @(negedge clk);
        chk("to_irq_cleared", irq, 0);

        reg_flush = 1; reg_div = 16'd1;
        @(negedge clk);
        reg_flush = 0;
        repeat (4) @(negedge clk);
        for (int c = 0; c < 4000; c++) begin
            bit quiet;
            quiet      = (c % 600) >= 400;
            core_valid = quiet ? 1'b0 : ($urandom_range(0, 2) == 0);
            core_data  = 8'($urandom);
            rd_ready   = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
            reg_flush  = !quiet && ($urandom_range(0, 199) == 0);
            ovr_clr    = ($urandom_range(0, 49) == 0);
            core_busy  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0)  reg_trig   = 2'($urandom);
            if ($urandom_range(0, 249) == 0) reg_en     = ~reg_en;
            if ($urandom_range(0, 149) == 0) reg_bits   = 2'($urandom);
            if ($urandom_range(0, 149) == 0) reg_parity = 1'($urandom);
            @(negedge clk);
        end
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
